matrix_job_sequencer: RTL and testbench

Upstream/downstream wrapper for matrix_multiplier. Accepts a job from a valid/ready word stream (config word, then matrix A and matrix B row-major) and writes it into the multiplier's memory map. Issues the start command, waits for result_ready, then reads the result matrix back out as a valid/ready stream. Lets a host drive the multiplier without knowing its address map.

---
 rtl/mjs_pkg.sv | 23 ++
 rtl/mjs_cfg_decode.sv | 27 ++
 rtl/matrix_job_sequencer.sv | 178 +++++++++++++++++
 tb/tb_matrix_job_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mjs_pkg.sv
// Shared types and memory-map constants for the matrix job sequencer.
package mjs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        READ,
        ERR
    } state_t;

    localparam logic [11:0] STATUS_ADDR = 12'd0;
    localparam logic [11:0] CONFIG_ADDR = 12'd1;
    localparam logic [11:0] A_BASE      = 12'd2;
    localparam logic [11:0] B_BASE      = 12'd1026;
    localparam logic [11:0] C_BASE      = 12'd2050;
    localparam logic [31:0] START_WORD  = 32'h8000_0000;
    localparam logic [15:0] MAX_WORDS   = 16'd1024;

endpackage

// File: rtl/mjs_cfg_decode.sv
// Combinational config-word decoder: splits M/K/KB/N, forms the three
// matrix sizes at 16 bits and flags whether the job fits the multiplier.
module mjs_cfg_decode
    import mjs_pkg::*;
(
    input  logic [31:0] cfg,
    output logic [15:0] mk,
    output logic [15:0] kn,
    output logic [15:0] mn,
    output logic        valid
);

    logic [7:0] m, k, kb, n;

    assign m  = cfg[31:24];
    assign k  = cfg[23:16];
    assign kb = cfg[15:8];
    assign n  = cfg[7:0];

    assign mk = {8'd0, m} * {8'd0, k};
    assign kn = {8'd0, k} * {8'd0, n};
    assign mn = {8'd0, m} * {8'd0, n};

    assign valid = (m != 8'd0) && (k != 8'd0) && (n != 8'd0) && (kb == k) &&
                   (mk <= MAX_WORDS) && (kn <= MAX_WORDS) && (mn <= MAX_WORDS);

endmodule

// File: rtl/matrix_job_sequencer.sv
// Streams a job (config, A, B) into matrix_multiplier's memory map, starts it,
// and streams the result back. Optional WAIT watchdog: define MJS_WATCHDOG_EN.
module matrix_job_sequencer
    import mjs_pkg::*;
#(
    parameter int READ_LATENCY    = 1,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] mm_data_in,
    output logic [11:0] mm_address,
    output logic        mm_write_enable,
    input  logic [31:0] mm_data_out,
    input  logic        mm_result_ready,
    output logic        busy,
    output logic        error
);

    state_t      state_q, state_d;
    logic [31:0] cfg_q;
    logic [15:0] mk_q, kn_q, mn_q;
    logic [15:0] cnt;
    logic [2:0]  lat;

    logic [15:0] dec_mk, dec_kn, dec_mn;
    logic        dec_ok;
    logic        accept, a_last, b_last, r_last, wd_timeout;

    mjs_cfg_decode u_dec (
        .cfg   (in_data),
        .mk    (dec_mk),
        .kn    (dec_kn),
        .mn    (dec_mn),
        .valid (dec_ok)
    );

    assign in_ready = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;
    assign a_last   = (cnt == mk_q - 16'd1);
    assign b_last   = (cnt == kn_q - 16'd1);
    assign r_last   = (cnt == mn_q - 16'd1);

`ifdef MJS_WATCHDOG_EN
    logic [31:0] wd_cnt;
    assign wd_timeout = (wd_cnt == 32'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset || state_q != WAIT) wd_cnt <= '0;
        else                           wd_cnt <= wd_cnt + 32'd1;
    end
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = dec_ok ? CFG : ERR;
            ERR:     state_d = IDLE;
            CFG:     if (cnt[0]) state_d = LOAD_A;
            LOAD_A:  if (accept && a_last) state_d = LOAD_B;
            LOAD_B:  if (accept && b_last) state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (mm_result_ready) state_d = READ;
                else if (wd_timeout) state_d = IDLE;
            end
            READ:    if (out_valid && out_ready && r_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_q           <= '0;
            mk_q            <= '0;
            kn_q            <= '0;
            mn_q            <= '0;
            cnt             <= '0;
            lat             <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_last        <= 1'b0;
            mm_data_in      <= '0;
            mm_address      <= '0;
            mm_write_enable <= 1'b0;
            error           <= 1'b0;
        end else begin
            mm_write_enable <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    error <= 1'b0;
                    cfg_q <= in_data;
                    mk_q  <= dec_mk;
                    kn_q  <= dec_kn;
                    mn_q  <= dec_mn;
                    cnt   <= '0;
                end
                ERR: error <= 1'b1;
                CFG: begin
                    // Clear the status word before publishing the config.
                    mm_write_enable <= 1'b1;
                    if (!cnt[0]) begin
                        mm_address <= STATUS_ADDR;
                        mm_data_in <= '0;
                        cnt        <= 16'd1;
                    end else begin
                        mm_address <= CONFIG_ADDR;
                        mm_data_in <= cfg_q;
                        cnt        <= '0;
                    end
                end
                LOAD_A: if (accept) begin
                    mm_write_enable <= 1'b1;
                    mm_address      <= A_BASE + cnt[11:0];
                    mm_data_in      <= in_data;
                    cnt             <= a_last ? 16'd0 : cnt + 16'd1;
                end
                LOAD_B: if (accept) begin
                    mm_write_enable <= 1'b1;
                    mm_address      <= B_BASE + cnt[11:0];
                    mm_data_in      <= in_data;
                    cnt             <= b_last ? 16'd0 : cnt + 16'd1;
                end
                START: begin
                    mm_write_enable <= 1'b1;
                    mm_address      <= STATUS_ADDR;
                    mm_data_in      <= START_WORD;
                end
                WAIT: begin
                    if (mm_result_ready) begin
                        mm_address <= C_BASE;
                        cnt        <= '0;
                        lat        <= '0;
                    end else if (wd_timeout) begin
                        error <= 1'b1;
                    end
                end
                READ: begin
                    // lat counts edges since the address was issued.
                    if (!out_valid) begin
                        if (lat == 3'(READ_LATENCY)) begin
                            out_data  <= mm_data_out;
                            out_valid <= 1'b1;
                            out_last  <= r_last;
                        end else begin
                            lat <= lat + 3'd1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!r_last) begin
                            cnt        <= cnt + 16'd1;
                            mm_address <= C_BASE + cnt[11:0] + 12'd1;
                            lat        <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_job_sequencer.sv
// Directed bench for matrix_job_sequencer with a 1-cycle-latency memory model.
module tb_matrix_job_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [31:0] mm_data_in;
    logic [11:0] mm_address;
    logic        mm_write_enable;
    logic [31:0] mm_data_out = '0;
    logic        mm_result_ready = 1'b0;
    logic        busy;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [43:0] wr_q[$];
    logic [32:0] out_q[$];

    matrix_job_sequencer #(.READ_LATENCY(1), .WATCHDOG_CYCLES(100)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .mm_data_in      (mm_data_in),
        .mm_address      (mm_address),
        .mm_write_enable (mm_write_enable),
        .mm_data_out     (mm_data_out),
        .mm_result_ready (mm_result_ready),
        .busy            (busy),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Result memory: each C word reads back as a tag of its own address.
    always @(posedge clk) mm_data_out <= {20'hC0DE0, mm_address};

    always @(posedge clk) begin
        if (reset && mm_write_enable) wr_q.push_back({mm_address, mm_data_in});
        if (reset && out_valid && out_ready) out_q.push_back({out_last, out_data});
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic send_word(input logic [31:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_word timeout word=%h", d);
        end
    endtask

    task automatic load_job(input logic [31:0] cfg, input int na, input int nb);
        send_word(cfg);
        for (int i = 0; i < na; i++) send_word(32'hA000_0000 + 32'(i));
        for (int j = 0; j < nb; j++) send_word(32'hB000_0000 + 32'(j));
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_q.size() < n && t < 500) begin @(negedge clk); t++; end
        n_cmp++;
        if (wr_q.size() < n) begin
            n_bad++;
            $display("FAIL wait_writes got %0d need %0d", wr_q.size(), n);
        end
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (out_q.size() < n && t < 1000) begin @(negedge clk); t++; end
        n_cmp++;
        if (out_q.size() < n) begin
            n_bad++;
            $display("FAIL wait_outs got %0d need %0d", out_q.size(), n);
        end
    endtask

    task automatic pulse_rr();
        @(negedge clk) mm_result_ready = 1'b1;
        @(negedge clk) mm_result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_last, mm_write_enable, busy, error} !== 6'b100000 ||
            out_data !== 32'd0 || mm_address !== 12'd0 || mm_data_in !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state flags=%b out_data=%h addr=%h din=%h exp flags=100000 zeros",
                     {in_ready, out_valid, out_last, mm_write_enable, busy, error},
                     out_data, mm_address, mm_data_in);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_job(input logic [31:0] cfg, input int m, input int k, input int n);
        logic [43:0] exp_w[$];
        logic [32:0] exp_o;
        wr_q.delete(); out_q.delete();
        out_ready = 1'b1;
        exp_w.push_back({12'd0, 32'd0});
        exp_w.push_back({12'd1, cfg});
        for (int i = 0; i < m * k; i++) exp_w.push_back({12'(2 + i), 32'hA000_0000 + 32'(i)});
        for (int j = 0; j < k * n; j++) exp_w.push_back({12'(1026 + j), 32'hB000_0000 + 32'(j)});
        exp_w.push_back({12'd0, 32'h8000_0000});
        load_job(cfg, m * k, k * n);
        wait_writes(exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL job_%h_write[%0d] got %h exp %h", cfg, i, wr_q[i], exp_w[i]);
            end
        end
        pulse_rr();
        wait_outs(m * n);
        for (int r = 0; r < m * n && r < out_q.size(); r++) begin
            exp_o = {(r == m * n - 1), 20'hC0DE0, 12'(2050 + r)};
            n_cmp++;
            if (out_q[r] !== exp_o) begin
                n_bad++;
                $display("FAIL job_%h_out[%0d] got %h exp %h", cfg, r, out_q[r], exp_o);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || wr_q.size() != exp_w.size()) begin
            n_bad++;
            $display("FAIL job_%h_end busy=%b writes=%0d exp busy=0 writes=%0d",
                     cfg, busy, wr_q.size(), exp_w.size());
        end
    endtask

    task automatic test_bad_config();
        wr_q.delete(); out_q.delete();
        send_word(32'h0403_0404);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL bad_cfg error=%b busy=%b writes=%0d exp 1 0 0", error, busy, wr_q.size());
        end
        send_word(32'h0101_0101);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_cfg_clear error=%b busy=%b exp 0 1", error, busy);
        end
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        wait_writes(5);
        pulse_rr();
        wait_outs(1);
        n_cmp++;
        if (out_q.size() < 1 || out_q[0] !== {1'b1, 20'hC0DE0, 12'd2050}) begin
            n_bad++;
            $display("FAIL bad_cfg_recover out=%h exp %h", out_q.size() ? out_q[0] : 33'h0,
                     {1'b1, 20'hC0DE0, 12'd2050});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic        l0;
        logic [11:0] a0;
        int t = 0;
        wr_q.delete(); out_q.delete();
        out_ready = 1'b0;
        load_job(32'h0202_0202, 4, 4);
        wait_writes(11);
        pulse_rr();
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        d0 = out_data; l0 = out_last; a0 = mm_address;
        n_cmp++;
        if (out_valid !== 1'b1 || d0 !== {20'hC0DE0, 12'd2050} || l0 !== 1'b0 || a0 !== 12'd2050) begin
            n_bad++;
            $display("FAIL bp_first valid=%b data=%h last=%b addr=%0d exp 1 c0de0802 0 2050",
                     out_valid, d0, l0, a0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0 || mm_address !== a0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] valid=%b data=%h last=%b addr=%0d exp 1 %h %b %0d",
                         c, out_valid, out_data, out_last, mm_address, d0, l0, a0);
            end
        end
        out_ready = 1'b1;
        wait_outs(4);
        for (int r = 0; r < 4 && r < out_q.size(); r++) begin
            n_cmp++;
            if (out_q[r] !== {(r == 3), 20'hC0DE0, 12'(2050 + r)}) begin
                n_bad++;
                $display("FAIL bp_out[%0d] got %h exp %h", r, out_q[r], {(r == 3), 20'hC0DE0, 12'(2050 + r)});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        out_ready = 1'b1;
        send_word(32'h0404_0404);
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i));
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_last, mm_write_enable, busy, error} !== 6'b100000 ||
            out_data !== 32'd0 || mm_address !== 12'd0 || mm_data_in !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset flags=%b out_data=%h addr=%h din=%h exp flags=100000 zeros",
                     {in_ready, out_valid, out_last, mm_write_enable, busy, error},
                     out_data, mm_address, mm_data_in);
        end
        reset = 1'b1;
        wr_q.delete();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_quiet writes=%0d busy=%b exp 0 0", wr_q.size(), busy);
        end
    endtask

`ifdef MJS_WATCHDOG_EN
    task automatic test_watchdog();
        wr_q.delete(); out_q.delete();
        load_job(32'h0101_0101, 1, 1);
        wait_writes(5);
        repeat (90) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_early busy=%b error=%b exp 1 0", busy, error);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || error !== 1'b1 || out_q.size() != 0) begin
            n_bad++;
            $display("FAIL wd_fire busy=%b error=%b outs=%0d exp 0 1 0", busy, error, out_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_job(32'h0404_0404, 4, 4, 4);
        test_job(32'h0203_0301, 2, 3, 1);
        test_bad_config();
        test_backpressure();
        test_reset_mid_load();
`ifdef MJS_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
